// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle between the E-stage datapath and the
// multiply/divide unit.
interface mult_div_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDOp;
  logic        start;
  logic        RdSel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MD;

  modport master (output A, B, MDOp, start, RdSel, input busy, HI, LO, MD);
  modport slave  (input A, B, MDOp, start, RdSel, output busy, HI, LO, MD);
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, models a fixed multi-cycle
// latency and commits the whole result at once when the countdown expires.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst,
  mult_div_unit_if.slave   bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_we_q, pend_we_d;

  md_op_e op;
  logic   launch;
  assign op     = md_op_e'(bus.MDOp);
  assign launch = bus.start && (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});

  // Products and quotients are formed from the live operands; they only
  // matter on the launch edge, where they are captured into pend_*.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'b0, bus.A} * {32'b0, bus.B};

  // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN
  // instead of overflowing; a zero divisor is replaced to keep the divider
  // defined, and its result is never committed.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, den, q_mag, r_mag, quot, rem;
  assign a_neg = (op == OP_DIV) && bus.A[31];
  assign b_neg = (op == OP_DIV) && bus.B[31];
  assign a_mag = a_neg ? (32'd0 - bus.A) : bus.A;
  assign b_mag = b_neg ? (32'd0 - bus.B) : bus.B;
  assign den   = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / den;
  assign r_mag = a_mag % den;
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  logic [31:0] res_hi, res_lo;
  logic        res_we;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    res_we = 1'b1;
    case (op)
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        res_hi = rem;
        res_lo = quot;
        res_we = (bus.B != 32'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_we_d = res_we;
          cnt_d     = (op inside {OP_MULT, OP_MULTU}) ? MULT_LOAD : DIV_LOAD;
          state_d   = RUN;
        end else if (op == OP_MTHI) begin
          hi_d = bus.A;
        end else if (op == OP_MTLO) begin
          lo_d = bus.A;
        end
      end
      RUN: begin
        // All inputs are ignored here; only the countdown advances.
        if (cnt_q == CNT_ONE) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.MD   = bus.RdSel ? hi_q : lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit of the pipelined MIPS core; owns the HI/LO architectural registers.
- Consumes forwarded rs/rt operands from the E-stage operand muxes.
- Produces the `MD` value that the downstream pipeline registers carry to the `MD` write-data source at writeback.
- Exposes `busy` so the hazard unit stalls D when an MD instruction arrives while an operation is pending.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu
DIV_CYCLES, 10, busy duration in cycles for div/divu

Ports:
clk    input   1   system clock, rising edge
rst    input   1   synchronous active-high reset
A      input   32  operand rs (forwarded)
B      input   32  operand rt (forwarded)
MDOp   input   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
start  input   1   launch pulse; meaningful only with MDOp 1-4
RdSel  input   1   0 selects LO, 1 selects HI for MD
busy   output  1   operation in flight
HI     output  32  HI register
LO     output  32  LO register
MD     output  32  combinational: RdSel ? HI : LO

Behaviour:
Interface and reset:
- One clock `clk`. Reset `rst` is synchronous and active-high.
- On a clk edge with rst=1: HI=0, LO=0, busy=0, cycle counter=0, pending result discarded.
- rst overrides every other input, including reset mid-operation: no HI/LO update ever occurs for the aborted op.

States:
- IDLE (busy=0) and RUN (busy=1). The counter counts down while in RUN.

IDLE transitions:
- start=1 with MDOp in 1-4 at edge t:
  - latch A, B and op; compute result into internal pending HI/LO;
  - load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy is 1 in cycles t+1 through t+N.
- MDOp=MTHI (5) with busy=0: HI<=A at the edge; LO unchanged. start is not required.
- MDOp=MTLO (6) with busy=0: LO<=A at the edge; HI unchanged. start is not required.
- start=1 with MDOp 0, 5, 6 or 7: no launch. MTHI/MTLO still act as above.

RUN transitions:
- Counter decrements each edge.
- At the edge ending cycle t+N: HI/LO <= pending values, busy<=0, return to IDLE.
- Results are visible on HI/LO/MD from cycle t+N+1.
- Earlier cycles show the old HI/LO; no partial results are ever visible.
- In RUN, start, MTHI and MTLO are all ignored. The hazard unit guarantees they do not occur; the unit must still not corrupt state if they do.

Arithmetic:
- MULT: 64-bit signed product of A and B; HI=[63:32], LO=[31:0].
- MULTU: 64-bit unsigned product of A and B; HI=[63:32], LO=[31:0].
- DIV (signed):
  - LO=quotient, truncated toward zero; HI=remainder, sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (B=0, div or divu): busy still runs the full DIV_CYCLES; HI and LO are left unchanged at completion.
- Operands are sampled only at the start edge. Later changes on A/B have no effect.

Back-to-back:
- A new start is accepted in the first cycle with busy=0, i.e. the cycle after completion.

Test Plan:
- Signed mult: A=0xFFFFFFFD (-3), B=5, MDOp=MULT, start pulse -> busy=1 for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFF1; HI/LO hold old values until then.
- Unsigned mult: A=B=0xFFFFFFFF, MDOp=MULTU -> HI=0xFFFFFFFE, LO=0x00000001. Changing A/B during busy does not affect the result.
- Signed div: A=0xFFFFFFF9 (-7), B=2, MDOp=DIV -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Overflow case 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11, LO=0x22 via MTHI/MTLO; DIVU A=7, B=0 -> busy 10 cycles; HI=0x11, LO=0x22 after completion. MD shows 0x22 with RdSel=0 and 0x11 with RdSel=1.
- MTHI/MTLO and ignore-while-busy: MTHI A=0x1234 -> HI=0x1234 next cycle. During a MULT run, MTLO and start pulses are ignored; the final HI/LO equal the product only.
- Reset mid-op: launch DIV, assert rst in the 4th busy cycle -> next cycle busy=0, HI=LO=0, and no update at the original completion cycle. A start right after rst deasserts proceeds normally.
